native_bist_master: RTL

//  Pattern-generating initiator for one LiteDRAM native user port: drives cmd/wdata, sinks and checks rdata.

---
 rtl/native_bist_master.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/native_bist_master.sv
// Pattern-generating BIST initiator for one LiteDRAM native user port.
// Writes and/or read-checks a linear range of single-beat commands.
module native_bist_master #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    length,
  input  logic [31:0]         seed,
  output logic                busy,
  output logic                done,
  output logic [15:0]         err_count,
  output logic [LEN_W-1:0]    first_err_idx,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_first,
  output logic                cmd_last,
  output logic                cmd_payload_we,
  output logic                cmd_payload_mw,
  output logic [ADDR_W-1:0]   cmd_payload_addr,
  output logic                wdata_valid,
  input  logic                wdata_ready,
  output logic                wdata_first,
  output logic                wdata_last,
  output logic [DATA_W-1:0]   wdata_payload_data,
  output logic [DATA_W/8-1:0] wdata_payload_we,
  input  logic                rdata_valid,
  output logic                rdata_ready,
  input  logic                rdata_first,
  input  logic                rdata_last,
  input  logic [DATA_W-1:0]   rdata_payload_data
);

  localparam int LANES = DATA_W / 32;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [31:0]       seed_q;
  logic [LEN_W-1:0]  cmd_idx;
  logic [LEN_W-1:0]  wd_idx;
  logic [LEN_W-1:0]  rd_idx;
  logic              in_wr;
  logic              in_rd;
  logic              unused_ok;

  function automatic logic [DATA_W-1:0] pat(
    input logic [31:0]      s,
    input logic [LEN_W-1:0] k
  );
    logic [DATA_W-1:0] d;
    logic [31:0]       b;
    b = s + 32'(k) * 32'(LANES);
    for (int i = 0; i < LANES; i++)
      d[32*i +: 32] = b + 32'(i);
    return d;
  endfunction

  assign in_wr = (state == WR);
  assign in_rd = (state == RD);

  // Handshake outputs decode only flopped state, never ready inputs.
  assign busy               = in_wr || in_rd;
  assign done               = (state == DONE);
  assign cmd_valid          = busy && (cmd_idx < len_q);
  assign cmd_first          = 1'b1;
  assign cmd_last           = 1'b1;
  assign cmd_payload_we     = in_wr;
  assign cmd_payload_mw     = 1'b0;
  assign cmd_payload_addr   = base_q + ADDR_W'(cmd_idx);
  assign wdata_valid        = in_wr && (wd_idx < cmd_idx);
  assign wdata_first        = 1'b1;
  assign wdata_last         = 1'b1;
  assign wdata_payload_data = pat(seed_q, wd_idx);
  assign wdata_payload_we   = '1;
  assign rdata_ready        = in_rd;
  assign unused_ok          = &{1'b0, rdata_first, rdata_last};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mode_q        <= '0;
      base_q        <= '0;
      len_q         <= '0;
      seed_q        <= '0;
      cmd_idx       <= '0;
      wd_idx        <= '0;
      rd_idx        <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q        <= mode;
            base_q        <= base_addr;
            len_q         <= length;
            seed_q        <= seed;
            cmd_idx       <= '0;
            wd_idx        <= '0;
            rd_idx        <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            if (length == '0)
              state <= DONE;
            else if (mode == 2'd1)
              state <= RD;
            else
              state <= WR;
          end
        end
        WR: begin
          if (cmd_valid && cmd_ready)
            cmd_idx <= cmd_idx + LEN_W'(1);
          if (wdata_valid && wdata_ready)
            wd_idx <= wd_idx + LEN_W'(1);
          if (cmd_idx == len_q && wd_idx == len_q) begin
            cmd_idx <= '0;
            state   <= (mode_q == 2'd0) ? DONE : RD;
          end
        end
        RD: begin
          if (cmd_valid && cmd_ready)
            cmd_idx <= cmd_idx + LEN_W'(1);
          if (rdata_valid && rd_idx != len_q) begin
            rd_idx <= rd_idx + LEN_W'(1);
            if (rdata_payload_data != pat(seed_q, rd_idx)) begin
              if (err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
              if (err_count == '0)
                first_err_idx <= rd_idx;
            end
          end
          if (rd_idx == len_q)
            state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
